// File: rtl/fp16_pkg.sv
// Shared FP16 constants, the collector FSM state type and a sign-clamp helper.
package fp16_pkg;

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
  localparam int unsigned FP16_SIGN_BIT = 15;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FLUSH,
    CAPTURE,
    DRAIN
  } collector_state_e;

  // Any word with the sign bit set (including -0 and negative NaN) becomes +0.
  function automatic logic [15:0] fp16_relu(input logic [15:0] word);
    return word[FP16_SIGN_BIT] ? FP16_POS_ZERO : word;
  endfunction

endpackage

// File: rtl/fp16_collect_drain.sv
// Snapshot buffer for NUM_PE accumulator words plus a valid/ready serializer.
// Optional macro FP16_COLLECT_RELU_EN clamps negative words to +0 at snapshot time.
module fp16_collect_drain
  import fp16_pkg::*;
#(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 drain_en,
  input  logic [NUM_PE*16-1:0] acc_vec,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [15:0]          out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 last_fire
);

  logic [15:0]      snap_q [NUM_PE];
  logic [15:0]      snap_d [NUM_PE];
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             at_last;
  logic             fire;

  // Words entering the snapshot, optionally sign-clamped.
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
`ifdef FP16_COLLECT_RELU_EN
      snap_d[i] = fp16_relu(acc_vec[i*16 +: 16]);
`else
      snap_d[i] = acc_vec[i*16 +: 16];
`endif
    end
  end

  // Read pointer: reset on load, advance on each accepted word, wrap after the last.
  always_comb begin
    at_last = (idx_q == IDX_W'(NUM_PE - 1));
    fire    = drain_en & out_ready;
    idx_d   = idx_q;
    if (load) begin
      idx_d = '0;
    end else if (fire) begin
      idx_d = at_last ? '0 : idx_q + 1'b1;
    end
  end

  // Snapshot and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      for (int i = 0; i < NUM_PE; i++) begin
        snap_q[i] <= FP16_POS_ZERO;
      end
    end else begin
      idx_q <= idx_d;
      if (load) begin
        for (int i = 0; i < NUM_PE; i++) begin
          snap_q[i] <= snap_d[i];
        end
      end
    end
  end

  // Outputs read zero outside DRAIN; inside DRAIN they only move on a handshake.
  always_comb begin
    out_valid = drain_en;
    out_data  = drain_en ? snap_q[idx_q] : FP16_POS_ZERO;
    out_idx   = drain_en ? idx_q : '0;
    out_last  = drain_en & at_last;
    last_fire = fire & at_last;
  end

endmodule

// File: rtl/fp16_mac_result_collector.sv
// Tile sequencer and result readout for a row of FP16 MAC units.
// Optional macro FP16_COLLECT_RELU_EN enables sign clamping of collected words.
module fp16_mac_result_collector
  import fp16_pkg::*;
#(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned K_W    = 8,
  parameter int unsigned IDX_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [K_W-1:0]       cfg_k,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mac_enable,
  output logic                 mac_acc_clear,
  output logic                 mac_op_zero,
  input  logic [NUM_PE*16-1:0] acc_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 tile_done
);

  collector_state_e state_q, state_d;
  logic [K_W-1:0]   k_lat_q, k_lat_d;
  logic [K_W-1:0]   k_cnt_q, k_cnt_d;
  logic             tile_done_q;
  logic             snap_load;
  logic             drain_en;
  logic             last_fire;

  // Next-state and MAC control decode.
  always_comb begin
    state_d       = state_q;
    k_lat_d       = k_lat_q;
    k_cnt_d       = k_cnt_q;
    in_ready      = 1'b0;
    mac_enable    = 1'b0;
    mac_acc_clear = 1'b0;
    mac_op_zero   = 1'b0;
    snap_load     = 1'b0;
    drain_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_lat_d = (cfg_k == '0) ? K_W'(1) : cfg_k;
          k_cnt_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_ready      = 1'b1;
        mac_enable    = in_valid;
        // First product of the tile overwrites the previous tile's sum.
        mac_acc_clear = in_valid & (k_cnt_q == '0);
        if (in_valid) begin
          k_cnt_d = k_cnt_q + 1'b1;
          if (k_cnt_q == k_lat_q - 1'b1) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Zero-operand beat pushes each accumulator out to acc_out.
        mac_enable    = 1'b1;
        mac_acc_clear = 1'b1;
        mac_op_zero   = 1'b1;
        state_d       = CAPTURE;
      end
      CAPTURE: begin
        snap_load = 1'b1;
        state_d   = DRAIN;
      end
      DRAIN: begin
        drain_en = 1'b1;
        if (last_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, tile length and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_lat_q     <= '0;
      k_cnt_q     <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_lat_q     <= k_lat_d;
      k_cnt_q     <= k_cnt_d;
      tile_done_q <= last_fire;
    end
  end

  // Status outputs.
  always_comb begin
    busy      = (state_q != IDLE);
    tile_done = tile_done_q;
  end

  fp16_collect_drain #(
    .NUM_PE (NUM_PE),
    .IDX_W  (IDX_W)
  ) u_drain (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (snap_load),
    .drain_en  (drain_en),
    .acc_vec   (acc_vec),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .last_fire (last_fire)
  );

endmodule

// File: tb/tb_fp16_mac_result_collector.sv
// Scoreboard bench for fp16_mac_result_collector: directed tiles with hand-derived
// cycle masks; a monitor pops expected words on every output handshake.
module tb_fp16_mac_result_collector;

  localparam int NUM_PE = 4;
  localparam int K_W    = 8;
  localparam int IDX_W  = 2;
  localparam int NCYC   = 24;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [K_W-1:0]       cfg_k;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mac_enable;
  logic                 mac_acc_clear;
  logic                 mac_op_zero;
  logic [NUM_PE*16-1:0] acc_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
  logic                 tile_done;

  typedef struct packed {
    logic [15:0]      data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  fp16_mac_result_collector #(
    .NUM_PE (NUM_PE),
    .K_W    (K_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_k         (cfg_k),
    .busy          (busy),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mac_enable    (mac_enable),
    .mac_acc_clear (mac_acc_clear),
    .mac_op_zero   (mac_op_zero),
    .acc_vec       (acc_vec),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_idx       (out_idx),
    .out_last      (out_last),
    .tile_done     (tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef FP16_COLLECT_RELU_EN
    return w[15] ? 16'h0000 : w;
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output word must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got idx %0d data 0x%0h, expected no word",
                   out_idx, out_data);
        end else begin
          e = sb_q.pop_front();
          check("word_data", 32'(out_data), 32'(e.data));
          check("word_idx", 32'(out_idx), 32'(e.idx));
          check("word_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  // One tile: masks index cycles after the start edge (cycle 0 is the first ACCUM cycle).
  task automatic run_tile(
    input string                name,
    input logic [K_W-1:0]       cfg,
    input logic [NUM_PE*16-1:0] acc,
    input int                   n_push,
    input logic [31:0]          iv_mask,
    input logic [31:0]          or_mask,
    input logic [31:0]          st_mask,
    input logic [31:0]          rst_mask,
    input logic [31:0]          e_busy,
    input logic [31:0]          e_en,
    input logic [31:0]          e_clr,
    input logic [31:0]          e_opz,
    input logic [31:0]          e_inr,
    input logic [31:0]          e_vld,
    input logic [31:0]          e_done,
    input logic [15:0]          hold_data,
    input logic [IDX_W-1:0]     hold_idx,
    input int                   e_hold
  );
    logic [31:0] o_busy, o_en, o_clr, o_opz, o_inr, o_vld, o_done, o_zero;
    int          stall_cnt, stall_ok;
    o_busy = '0; o_en = '0; o_clr = '0; o_opz = '0;
    o_inr = '0; o_vld = '0; o_done = '0; o_zero = '0;
    stall_cnt = 0;
    stall_ok  = 0;
    acc_vec = acc;
    for (int i = 0; i < n_push; i++) begin
      sb_q.push_back('{data: exp_word(acc[i*16 +: 16]), idx: IDX_W'(i),
                       last: (i == NUM_PE - 1)});
    end
    cfg_k = cfg;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      cfg_k     = 8'd7;  // later changes must not affect the running tile
      in_valid  = iv_mask[c];
      out_ready = or_mask[c];
      start     = st_mask[c];
      rst_n     = ~rst_mask[c];
      @(negedge clk);
      o_busy[c] = busy;
      o_en[c]   = mac_enable;
      o_clr[c]  = mac_acc_clear;
      o_opz[c]  = mac_op_zero;
      o_inr[c]  = in_ready;
      o_vld[c]  = out_valid;
      o_done[c] = tile_done;
      o_zero[c] = ({busy, in_ready, mac_enable, mac_acc_clear, mac_op_zero, out_valid,
                    out_data, out_idx, out_last, tile_done} == '0);
      if (out_valid && !out_ready) begin
        stall_cnt++;
        if (out_data == hold_data && out_idx == hold_idx) stall_ok++;
      end
      tick();
    end
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check({name, "_busy"}, o_busy & 32'hFFFFFF, e_busy);
    check({name, "_mac_enable"}, o_en & 32'hFFFFFF, e_en);
    check({name, "_acc_clear"}, o_clr & 32'hFFFFFF, e_clr);
    check({name, "_op_zero"}, o_opz & 32'hFFFFFF, e_opz);
    check({name, "_in_ready"}, o_inr & 32'hFFFFFF, e_inr);
    check({name, "_out_valid"}, o_vld & 32'hFFFFFF, e_vld);
    check({name, "_tile_done"}, o_done & 32'hFFFFFF, e_done);
    check({name, "_stall_cycles"}, stall_cnt, e_hold);
    check({name, "_held_word"}, stall_ok, e_hold);
    if (rst_mask != 0) check({name, "_reset_outputs_zero"}, o_zero & rst_mask, rst_mask);
    check({name, "_scoreboard_drained"}, sb_q.size(), 0);
  endtask

  localparam logic [63:0] ACC_BASIC = {16'h0000, 16'hC000, 16'h4000, 16'h3C00};

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_k = '0; in_valid = 1'b0;
    out_ready = 1'b1; acc_vec = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {7'd0, busy, in_ready, mac_enable, mac_acc_clear, mac_op_zero, out_valid,
           out_data, out_idx, out_last, tile_done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic K=3: 3 accum + flush + capture + 4 drain = 9 busy cycles.
    run_tile("basic", 8'd3, ACC_BASIC, 4, '1, '1, '0, '0,
             32'h1FF, 32'hF, 32'h9, 32'h8, 32'h7, 32'h1E0, 32'h200, 16'h0, '0, 0);
    // in_valid low on cycles 1,2: beats at 0,3,4, flush at 5.
    run_tile("stall", 8'd3, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4,
             32'hFFFFFFF9, '1, '0, '0,
             32'h7FF, 32'h39, 32'h21, 32'h20, 32'h1F, 32'h780, 32'h800, 16'h0, '0, 0);
    // out_ready low on cycles 6..8 while idx 1 (0x4000) is presented.
    run_tile("backpressure", 8'd3, ACC_BASIC, 4, '1, 32'hFFFFFE3F, '0, '0,
             32'hFFF, 32'hF, 32'h9, 32'h8, 32'h7, 32'hFE0, 32'h1000, 16'h4000, 2'd1, 3);
    // cfg_k = 0 runs as K = 1.
    run_tile("k_zero", 8'd0, {16'h5555, 16'h6666, 16'h7777, 16'h0123}, 4, '1, '1, '0, '0,
             32'h7F, 32'h3, 32'h3, 32'h2, 32'h1, 32'h78, 32'h80, 16'h0, '0, 0);
    // start pulsed during ACCUM is ignored.
    run_tile("start_busy", 8'd3, {16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D}, 4,
             '1, '1, 32'h2, '0,
             32'h1FF, 32'hF, 32'h9, 32'h8, 32'h7, 32'h1E0, 32'h200, 16'h0, '0, 0);
    // Reset while idx 2 is presented: two words seen, no tile_done afterwards.
    run_tile("reset_drain", 8'd3, ACC_BASIC, 2, '1, 32'hFFFFFF7F, '0, 32'h180,
             32'h7F, 32'hF, 32'h9, 32'h8, 32'h7, 32'h60, 32'h0, 16'h0, '0, 0);
    // Negative words: clamped to +0 when the ReLU build is selected, bit-exact otherwise.
    run_tile("negatives", 8'd3, {16'hFE00, 16'hC000, 16'h8000, 16'h3C00}, 4, '1, '1, '0, '0,
             32'h1FF, 32'hF, 32'h9, 32'h8, 32'h7, 32'h1E0, 32'h200, 16'h0, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_mac_result_collector.md
Name: fp16_mac_result_collector

Overview:
- Control and readout end of the FP16 approximate MAC array.
- Sequences one tile of K multiply-accumulate beats into a row of NUM_PE MAC units: drives enable and acc_clear, and handshakes operand beats from the feeder.
- Issues one flush beat so each PE's acc_out shows its final sum, snapshots all NUM_PE results, and streams them out one FP16 word per valid/ready beat.

Parameters:
- NUM_PE, 4, number of MAC units whose acc_out is collected (1..16).
- K_W, 8, width of the tile-length configuration cfg_k.
- IDX_W, 2, width of out_idx; must satisfy 2**IDX_W >= NUM_PE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a tile; sampled only in IDLE.
- cfg_k  in  K_W  products per tile; latched on accepted start; 0 treated as 1.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  feeder has an operand beat on the array inputs.
- in_ready  out  1  collector accepts an operand beat.
- mac_enable  out  1  to every PE enable.
- mac_acc_clear  out  1  to every PE acc_clear.
- mac_op_zero  out  1  tells the feeder to drive a_in = w_in = 16'h0000 during flush.
- acc_vec  in  NUM_PE*16  concatenated PE acc_out values; PE0 in bits [15:0].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  16  FP16 result.
- out_idx  out  IDX_W  PE index of out_data.
- out_last  out  1  high with the final word of a tile.
- tile_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values: all outputs 0 and state IDLE; k_cnt, idx and the snapshot buffer cleared. Reset asserted mid-tile aborts at once; no tile_done is issued.
- IDLE:
  - in_ready = 0, mac_enable = 0.
  - start = 1 latches k_lat = max(cfg_k, 1), clears k_cnt, and moves to ACCUM on the next cycle.
- ACCUM:
  - in_ready = 1.
  - mac_enable = in_valid (combinational).
  - mac_acc_clear = in_valid & (k_cnt == 0), so the first product overwrites the previous tile's sum.
  - Each accepted beat increments k_cnt. The beat with k_cnt == k_lat-1 moves the FSM to FLUSH.
  - in_valid = 0 stalls the FSM with no PE update.
- FLUSH (exactly 1 cycle):
  - mac_enable = 1, mac_acc_clear = 1, mac_op_zero = 1, in_ready = 0.
  - This transfers each PE's accumulator to acc_out and loads the accumulator with 0*0. Go to CAPTURE.
- CAPTURE (1 cycle):
  - mac_enable = 0.
  - All NUM_PE words of acc_vec are registered into the snapshot buffer; idx = 0. Go to DRAIN.
- DRAIN:
  - out_valid = 1, out_data = buf[idx], out_idx = idx, out_last = (idx == NUM_PE-1).
  - On out_valid & out_ready, idx increments.
  - On the last word: go to IDLE, and tile_done pulses in the cycle after the handshake.
  - While out_ready = 0: out_data, out_idx and out_last are held stable.
- Other rules:
  - start while busy is ignored and not queued.
  - Tile latency with in_valid always high and out_ready always high: K ACCUM cycles + 1 flush + 1 capture + NUM_PE drain cycles.
  - No FP arithmetic inside the block except the optional ReLU; words pass through bit-exact.
  - NUM_PE = 1: out_last is high on the first drain word.
  - cfg_k changing after start has no effect on the running tile.

Optional Feature:
- Macro: FP16_COLLECT_RELU_EN.
- Defined: any snapshot word with bit 15 = 1 (including -0 and negative NaN) is output as 16'h0000; all other words pass unchanged. Applied at CAPTURE, so drain timing is unchanged.
- Undefined: words are output bit-exact.

Decomposition:
- Shared package fp16_pkg:
  - FP16 constants: FP16_POS_ZERO = 16'h0000, FP16_SIGN_BIT = 15.
  - Collector FSM state enum: IDLE, ACCUM, FLUSH, CAPTURE, DRAIN.
- Sub-module fp16_collect_drain: snapshot buffer plus valid/ready serializer with the idx counter and out_last.
- The top level holds the FSM, k_cnt and the MAC control outputs.

Test Plan:
- Basic tile: cfg_k = 3, NUM_PE = 4, PEs produce 0x3C00/0x4000/0xC000/0x0000.
  - mac_acc_clear on beat 1 only and one flush cycle.
  - Words emitted in order idx 0..3, out_last on idx 3, tile_done 1 cycle later.
  - Total 3+1+1+4 = 9 cycles.
- Operand stall: in_valid low for 2 cycles between beats 1 and 2.
  - mac_enable low exactly those 2 cycles; k_cnt holds; tile still collects 3 products.
- Output backpressure: out_ready low for 3 cycles on idx 1.
  - out_data = 0x4000 and out_idx = 1 held stable; no word skipped or duplicated.
- cfg_k = 0: behaves as K = 1, i.e. one ACCUM beat with mac_acc_clear = 1, then flush.
- Reset and start-while-busy:
  - rst_n low during DRAIN at idx 2 gives all outputs 0 and IDLE, with no tile_done.
  - start during ACCUM is ignored.
- FP16_COLLECT_RELU_EN defined: 0xC000 and 0x8000 are output as 0x0000; 0x3C00 is unchanged.
